// File: rtl/fp_div_seq.sv
// Sequential IEEE 754 single-precision divider: radix-2 restoring, one quotient
// bit per cycle, round-to-nearest-even, denormals flushed to zero.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);
  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t             state_q;
  logic [25:0]        rem_q;
  logic [23:0]        mb_q;
  logic [26:0]        q_q;
  logic [4:0]         cnt_q;
  logic               sign_q;
  logic signed [10:0] exp_q;
  logic [31:0]        y_q;
  logic               out_valid_q;

  logic [7:0]  ea, eb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_in;
  logic        special_d;
  logic [31:0] special_y_d;

  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign sign_in = a[31] ^ b[31];
  assign a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
  assign a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);

  // Priority order matters: NaN-producing cases must win over inf/zero results.
  always_comb begin
    special_d   = 1'b1;
    special_y_d = 32'h7FC00000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_y_d = 32'h7FC00000;
    end else if (a_inf) begin
      special_y_d = {sign_in, 31'h7F800000};
    end else if (b_inf) begin
      special_y_d = {sign_in, 31'h0};
    end else if (b_zero) begin
      special_y_d = {sign_in, 31'h7F800000};
    end else if (a_zero) begin
      special_y_d = {sign_in, 31'h0};
    end else begin
      special_d = 1'b0;
    end
  end

  logic        rem_ge;
  logic [25:0] rem_d;
  logic [26:0] q_d;

  always_comb begin
    rem_ge = (rem_q >= {2'b00, mb_q});
    rem_d  = rem_ge ? ((rem_q - {2'b00, mb_q}) << 1) : (rem_q << 1);
    q_d    = {q_q[25:0], rem_ge};
  end

  logic [22:0]        mant_d;
  logic               g_d, r_d, s_d, inc_d;
  logic signed [10:0] expadj_d, exp_fin_d;
  logic [23:0]        mant_rnd_d;
  logic [31:0]        norm_y_d;

  always_comb begin
    if (q_q[26]) begin
      mant_d   = q_q[25:3];
      g_d      = q_q[2];
      r_d      = q_q[1];
      s_d      = q_q[0] | (rem_q != 26'd0);
      expadj_d = 11'sd0;
    end else begin
      mant_d   = q_q[24:2];
      g_d      = q_q[1];
      r_d      = q_q[0];
      s_d      = (rem_q != 26'd0);
      expadj_d = -11'sd1;
    end
    inc_d      = g_d & (r_d | s_d | mant_d[0]);
    // Carry out of the 23-bit field leaves the low bits all zero, i.e. mant=0.
    mant_rnd_d = {1'b0, mant_d} + {23'd0, inc_d};
    exp_fin_d  = exp_q + expadj_d + $signed({10'd0, mant_rnd_d[23]});
    if (exp_fin_d >= 11'sd255) begin
      norm_y_d = {sign_q, 31'h7F800000};
    end else if (exp_fin_d <= 11'sd0) begin
      norm_y_d = {sign_q, 31'h0};
    end else begin
      norm_y_d = {sign_q, exp_fin_d[7:0], mant_rnd_d[22:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      mb_q        <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= sign_in;
            if (special_d) begin
              y_q         <= special_y_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              rem_q   <= {2'b00, 1'b1, a[22:0]};
              mb_q    <= {1'b1, b[22:0]};
              q_q     <= '0;
              cnt_q   <= '0;
              exp_q   <= $signed({3'd0, ea}) - $signed({3'd0, eb}) + 11'sd127;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd26) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          y_q         <= norm_y_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign y         = y_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed corner cases plus randomized
// operands against an arithmetic reference model.
module tb_fp_div_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int n_vec = 0;
  int n_err = 0;

  fp_div_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic bit is_special(input logic [31:0] av, input logic [31:0] bv);
    return (av[30:23] == 8'd0) || (av[30:23] == 8'd255) ||
           (bv[30:23] == 8'd0) || (bv[30:23] == 8'd255);
  endfunction

  // Reference: exact quotient of significands, RNE from the exact remainder.
  function automatic logic [31:0] ref_div(input logic [31:0] av, input logic [31:0] bv);
    logic        s;
    int          ea, eb, e;
    bit          an, bn, ai, bi, az, bz;
    logic [63:0] ma, mb, num, sig, rm;
    s  = av[31] ^ bv[31];
    ea = int'(av[30:23]);
    eb = int'(bv[30:23]);
    an = (ea == 255) && (av[22:0] != 0);
    bn = (eb == 255) && (bv[22:0] != 0);
    ai = (ea == 255) && (av[22:0] == 0);
    bi = (eb == 255) && (bv[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC00000;
    if (ai) return {s, 31'h7F800000};
    if (bi) return {s, 31'h0};
    if (bz) return {s, 31'h7F800000};
    if (az) return {s, 31'h0};
    ma = {40'd0, 1'b1, av[22:0]};
    mb = {40'd0, 1'b1, bv[22:0]};
    if (ma >= mb) begin
      num = ma << 23;
      e   = ea - eb + 127;
    end else begin
      num = ma << 24;
      e   = ea - eb + 126;
    end
    sig = num / mb;
    rm  = num % mb;
    if ((2 * rm > mb) || ((2 * rm == mb) && (sig % 2 == 1))) sig = sig + 1;
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      e   = e + 1;
    end
    if (e >= 255) return {s, 31'h7F800000};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp(input int mode);
    logic [31:0] v;
    v = $urandom;
    if (mode == 0) begin
      v[30:23] = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'd255;
      if ($urandom_range(0, 1) == 1) v[22:0] = 23'd0;
    end else if (mode >= 2) begin
      v[30:23] = 8'($urandom_range(100, 154));
    end
    return v;
  endfunction

  // One operation: accept, measure latency, optionally stall the consumer, drain.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input string tag,
                        input int hold);
    logic [31:0] ey;
    int          exp_lat, lat;
    ey      = ref_div(av, bv);
    exp_lat = is_special(av, bv) ? 0 : 28;
    check({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " y"}, y, ey);
    $display("op %s: %h / %h -> %h (expected %h), latency %0d", tag, av, bv, y, ey, lat);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check({tag, " hold_y"}, y, ey);
      check({tag, " hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_clr"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
    check({tag, " y_retained"}, y, ey);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2 rst = 1'b1;
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset y", y, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;

    run_op(32'h40C00000, 32'h40000000, "6/2", 0);
    run_op(32'h3F800000, 32'h40400000, "1/3", 0);
    run_op(32'h3F800000, 32'h00000000, "1/0", 0);
    run_op(32'h00000000, 32'h00000000, "0/0", 0);
    run_op(32'hBF800000, 32'h7F800000, "-1/inf", 0);
    run_op(32'h7F000000, 32'h00800000, "overflow", 0);
    run_op(32'h00800000, 32'h40000000, "underflow", 0);
    run_op(32'h7FC00001, 32'h3F800000, "nan/1", 0);
    run_op(32'hFF800000, 32'h3F800000, "-inf/1", 0);
    run_op(32'h40490FDB, 32'h402DF854, "pi/e", 5);

    // Reset during DIV: the in-flight operation must vanish.
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst y", y, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    run_op(32'h41200000, 32'h40A00000, "10/5", 0);

    for (int i = 0; i < 200; i++) begin
      int ma_sel, mb_sel;
      ma_sel = $urandom_range(0, 9);
      mb_sel = $urandom_range(0, 9);
      ra = rand_fp(ma_sel == 0 ? 0 : (ma_sel == 1 ? 1 : 2));
      rb = rand_fp(mb_sel == 0 ? 0 : (mb_sel == 1 ? 1 : 2));
      run_op(ra, rb, $sformatf("rnd%0d", i), (i % 25 == 0) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 Parameters: none; fixed IEEE 754 single precision (32-bit: sign 31, exponent 30:23, mantissa 22:0, bias 127).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand pair a, b presented.
REQ-005 in_ready  output  1  block accepts operands; high iff state IDLE and rst low.
REQ-006 a  input  32  dividend, IEEE 754 single.
REQ-007 b  input  32  divisor, IEEE 754 single.
REQ-008 out_valid  output  1  y holds a completed quotient.
REQ-009 out_ready  input  1  consumer takes y.
REQ-010 y  output  32  registered quotient a/b, IEEE 754 single.

Function
REQ-011 FSM states: IDLE, DIV, NORM, DONE; one operation in flight, no overlap.
REQ-012 Accept on edge with in_valid && in_ready; a, b, sign (a[31]^b[31]) captured; later input changes have no effect.
REQ-013 Exponent field 0 treated as zero (denormal inputs flushed); no denormal outputs.
REQ-014 Special cases, checked in order at accept, go IDLE->DONE directly (out_valid high in the cycle after accept):
- a or b NaN, 0/0, inf/inf -> 0x7FC00000.
- a inf -> signed inf.
- b inf -> signed zero.
- b zero -> signed inf.
- a zero -> signed zero.
REQ-015 Normal case: IDLE->DIV. Mantissas ma={1,a[22:0]}, mb={1,b[22:0]}.
REQ-016 Divider algorithm: radix-2 restoring, one quotient bit per DIV cycle.
REQ-017 Iteration count: exactly 27 iterations, producing q[26:0], q[26] weight 2^0; remainder kept.
REQ-018 After the 27th iteration: DIV->NORM.
REQ-019 NORM, q[26]=1: mant=q[25:3], G=q[2], R=q[1], S=q[0]|(rem!=0), expadj=0.
REQ-020 NORM, q[26]=0: mant=q[24:2], G=q[1], R=q[0], S=(rem!=0), expadj=-1.
REQ-021 Rounding: round-to-nearest-even; increment mant when G&(R|S|mant[0]); carry-out -> mant=0, exponent +1.
REQ-022 Exponent: E=ea-eb+127+expadj+carry, computed signed, at least 10 bits wide.
REQ-023 Range: E>=255 -> signed inf (0x7F800000|sign); E<=0 -> signed zero.
REQ-024 NORM->DONE: y registered, out_valid=1.
REQ-025 Latency, normal case: out_valid rises exactly 28 edges after the accepting edge.
REQ-026 DONE: y and out_valid held stable until out_valid && out_ready; that edge -> IDLE, out_valid=0.
REQ-027 DONE: in_ready=0 throughout; in_valid ignored; y retains last value in IDLE.
REQ-028 in_valid low in IDLE: no state change.

Reset
REQ-029 rst high: immediately, without waiting for clk, state=IDLE, out_valid=0, y=0x00000000, iteration counter=0, datapath registers cleared.
REQ-030 rst asserted in DIV, NORM, or DONE: operation discarded, no out_valid produced for it.
REQ-031 First edge after rst deasserts: a new operation is accepted normally.

Verification
REQ-032 a=0x40C00000, b=0x40000000 (6/2) -> y=0x40400000; out_valid exactly 28 edges after accept.
REQ-033 a=0x3F800000, b=0x40400000 (1/3) -> y=0x3EAAAAAB (round-up path).
REQ-034 Special values, each with out_valid one cycle after accept:
- 0x3F800000/0x00000000 -> 0x7F800000.
- 0x00000000/0x00000000 -> 0x7FC00000.
- 0xBF800000/0x7F800000 -> 0x80000000.
REQ-035 Range limits:
- 0x7F000000/0x00800000 -> 0x7F800000 (overflow).
- 0x00800000/0x40000000 -> 0x00000000 (underflow flush).
REQ-036 Backpressure: out_ready held low 5 cycles after out_valid, in_valid pulsed -> y stable, in_ready=0, no accept. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-037 Reset mid-operation: rst pulsed after 10 DIV iterations -> out_valid=0, in_ready=1 after release; next op 0x41200000/0x40A00000 -> 0x40000000.
